pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage MIPS core.
- Merges stall requests from the IF, ID, EX and MEM stages into the 6-bit stall vector that drives the PC and the if_id/id_ex/ex_mem/mem_wb pipeline registers.
- Turns committed exceptions and ERET into a pipeline flush plus a PC redirect.
- When an exception arrives while an instruction fetch is still outstanding on the bus, it delays the redirect until the fetch returns, then discards the stale instruction.
- Includes a stall watchdog for debug.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/stall_wdt.sv | 37 +++
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, exception codes and sequencer states for pipe_ctrl
package pipe_ctrl_pkg;

   localparam logic        Stop     = 1'b1;
   localparam logic        NoStop   = 1'b0;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   localparam logic [31:0] EXC_INT  = 32'h0000_0001;
   localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXC_BP   = 32'h0000_0009;
   localparam logic [31:0] EXC_RI   = 32'h0000_000A;
   localparam logic [31:0] EXC_OV   = 32'h0000_000C;
   localparam logic [31:0] EXC_ERET = 32'h0000_000E;

   // Stall vector bit order: PC, IF, ID, EX, MEM, WB
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_IF  = 2'd1,
      REDIRECT = 2'd2
   } seq_state_e;

endpackage

// File: rtl/stall_wdt.sv
// rtl/stall_wdt.sv - saturating stalled-cycle counter with sticky timeout flag
module stall_wdt #(
   parameter int WDT_LIMIT = 1024,
   parameter int WDT_W     = 11
) (
   input  logic clk,
   input  logic reset,
   input  logic pc_stalled_i,
   output logic stall_timeout_o
);

   localparam logic [WDT_W-1:0] LIMIT_C = WDT_W'(WDT_LIMIT);

   logic [WDT_W-1:0] count_q, count_d;
   logic             timeout_q, timeout_d;

   always_comb begin
      count_d = '0;
      if (pc_stalled_i) begin
         count_d = (count_q == LIMIT_C) ? count_q : count_q + 1'b1;
      end
      timeout_d = timeout_q | (count_d == LIMIT_C);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, exception flush and PC redirect sequencer
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int          WDT_LIMIT  = 1024,
   parameter int          WDT_W      = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        if_busy,
   input  logic [31:0] except_type,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic        pc_redirect,
   output logic [31:0] new_pc,
   output logic        stall_timeout
);

   seq_state_e  state_q, state_d;
   logic [31:0] target_q, target_d;
   logic        exc_valid;
   logic [31:0] exc_target;

   assign exc_valid  = (except_type != ZeroWord);
   assign exc_target = (except_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      stall       = STALL_NONE;
      flush       = 1'b0;
      pc_redirect = 1'b0;
      new_pc      = ZeroWord;

      case (state_q)
         RUN: begin
            if (exc_valid) begin
               flush = 1'b1;
               if (!if_busy) begin
                  pc_redirect = 1'b1;
                  new_pc      = exc_target;
               end else begin
                  // Fetch still on the bus: hold the target until it returns
                  target_d = exc_target;
                  state_d  = WAIT_IF;
               end
            end else if (stallreq_mem) begin
               stall = STALL_MEM;
            end else if (stallreq_ex) begin
               stall = STALL_EX;
            end else if (stallreq_id) begin
               stall = STALL_ID;
            end else if (stallreq_if) begin
               stall = STALL_IF;
            end
         end
         WAIT_IF: begin
            stall = STALL_IF;
            if (!if_busy) begin
               state_d = REDIRECT;
            end
         end
         REDIRECT: begin
            // Flush drops the stale word that the late fetch wrote into if_id
            flush       = 1'b1;
            pc_redirect = 1'b1;
            new_pc      = target_q;
            state_d     = RUN;
         end
         default: state_d = RUN;
      endcase

      if (reset) begin
         stall       = STALL_NONE;
         flush       = 1'b0;
         pc_redirect = 1'b0;
         new_pc      = ZeroWord;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         target_q <= ZeroWord;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   stall_wdt #(
      .WDT_LIMIT (WDT_LIMIT),
      .WDT_W     (WDT_W)
   ) u_stall_wdt (
      .clk             (clk),
      .reset           (reset),
      .pc_stalled_i    (stall[0]),
      .stall_timeout_o (stall_timeout)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

   localparam int          LIMIT  = 4;
   localparam logic [31:0] VECTOR = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic        if_busy;
   logic [31:0] except_type, cp0_epc;
   logic [5:0]  stall;
   logic        flush, pc_redirect, stall_timeout;
   logic [31:0] new_pc;

   int n_chk = 0;
   int n_err = 0;

   // Model: pending redirect bookkeeping and watchdog run length
   bit          m_waiting = 0;
   bit          m_redir_due = 0;
   logic [31:0] m_target = '0;
   int          m_run = 0;
   bit          m_timeout = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .EXC_VECTOR (VECTOR),
      .WDT_LIMIT  (LIMIT),
      .WDT_W      (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stallreq_if   (stallreq_if),
      .stallreq_id   (stallreq_id),
      .stallreq_ex   (stallreq_ex),
      .stallreq_mem  (stallreq_mem),
      .if_busy       (if_busy),
      .except_type   (except_type),
      .cp0_epc       (cp0_epc),
      .stall         (stall),
      .flush         (flush),
      .pc_redirect   (pc_redirect),
      .new_pc        (new_pc),
      .stall_timeout (stall_timeout)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: apply inputs, check combinational outputs, then advance the model
   task automatic drive(input bit rst, input bit [3:0] req, input bit busy,
                        input logic [31:0] exc, input logic [31:0] epc);
      logic [5:0]  e_stall;
      bit          e_flush, e_redir;
      logic [31:0] e_pc, tgt;
      int          lvl;
      @(negedge clk);
      reset = rst;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
      if_busy = busy;
      except_type = exc;
      cp0_epc = epc;
      #1;
      e_stall = '0; e_flush = 0; e_redir = 0; e_pc = '0;
      tgt = (exc == 32'hE) ? epc : VECTOR;
      if (rst) begin
         m_waiting = 0; m_redir_due = 0; m_target = '0;
      end else if (m_redir_due) begin
         e_flush = 1; e_redir = 1; e_pc = m_target;
         m_redir_due = 0;
      end else if (m_waiting) begin
         e_stall = 6'b000011;
         if (!busy) begin
            m_waiting = 0; m_redir_due = 1;
         end
      end else if (exc != 0) begin
         e_flush = 1;
         if (!busy) begin
            e_redir = 1; e_pc = tgt;
         end else begin
            m_waiting = 1; m_target = tgt;
         end
      end else begin
         lvl = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
         e_stall = 6'((1 << lvl) - 1);
      end
      check_val("stall", 32'(stall), 32'(e_stall));
      check_val("flush", 32'(flush), 32'(e_flush));
      check_val("pc_redirect", 32'(pc_redirect), 32'(e_redir));
      check_val("new_pc", new_pc, e_pc);
      check_val("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
      if (rst) begin
         m_run = 0; m_timeout = 0;
      end else begin
         m_run = e_stall[0] ? ((m_run < LIMIT) ? m_run + 1 : LIMIT) : 0;
         if (m_run == LIMIT) m_timeout = 1;
      end
   endtask

   function automatic logic [31:0] pick_exc();
      logic [31:0] codes [6] = '{32'h1, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE};
      if ($urandom_range(0, 7) != 0) return 32'h0;
      if ($urandom_range(0, 5) == 0) return $urandom | 32'h1;
      return codes[$urandom_range(0, 5)];
   endfunction

   initial begin
      reset = 1; if_busy = 0; except_type = '0; cp0_epc = '0;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
      @(posedge clk);

      drive(1, 4'hF, 0, 32'h8, 32'h0);
      drive(0, 4'hF, 0, 32'h0, 32'h0);
      drive(0, 4'hF, 0, 32'h8, 32'h0);
      drive(0, 4'b0110, 0, 32'h0, 32'h0);
      drive(0, 4'b0001, 0, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'hE, 32'h8000_1234);
      drive(0, 4'b0100, 0, 32'h0, 32'h0);

      drive(0, 4'b0000, 1, 32'hC, 32'h0);
      repeat (3) drive(0, 4'hF, 1, 32'h8, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);
      drive(0, 4'b0010, 0, 32'h0, 32'h0);

      drive(0, 4'b0000, 1, 32'h9, 32'h0);
      drive(0, 4'b0000, 1, 32'h0, 32'h0);
      drive(1, 4'b0000, 1, 32'h0, 32'h0);
      drive(0, 4'b0100, 1, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);

      drive(0, 4'b0000, 1, 32'hE, 32'h1234_5678);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);

      drive(1, 4'b0000, 0, 32'h0, 32'h0);
      repeat (5) drive(0, 4'b1000, 0, 32'h0, 32'h0);
      repeat (3) drive(0, 4'b0000, 0, 32'h0, 32'h0);
      drive(1, 4'b0000, 0, 32'h0, 32'h0);
      drive(0, 4'b0000, 0, 32'h0, 32'h0);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 63) == 0), 4'($urandom),
               ($urandom_range(0, 2) == 0), pick_exc(), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
